// File: rtl/fnd_scan_controller.sv
// Multiplexed FND digit scanner: time-slices NUM_DIGITS select lines with an
// all-off anti-ghosting window at the start of every slot.
module fnd_scan_controller #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_blank,
  input  logic [NUM_DIGITS-1:0] i_digit_mask,
  output logic [NUM_DIGITS-1:0] o_digit,
  output logic [IW-1:0]         o_digit_idx,
  output logic                  o_frame_start
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_e;

  localparam logic [CW-1:0]         CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF  = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] ONE_LSB  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   sel_onehot_s;

  // Slot phase depends only on the position within the slot.
  function automatic state_e slot_phase(input logic [CW-1:0] c);
    if (32'(c) < BLANK_CYCLES) begin
      return S_BLANK;
    end else begin
      return S_ON;
    end
  endfunction

  // State, counters and all outputs registered together so outputs track next-state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      digit_q <= ALL_OFF;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
    end
  end

  // Next-state timing: disable wins, a fresh enable restarts at slot 0, otherwise advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (!i_en) begin
      state_d = S_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == S_OFF) begin
      cnt_d   = '0;
      idx_d   = '0;
      state_d = slot_phase(CW'(0));
      frame_d = 1'b1;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
      end
      state_d = slot_phase(cnt_d);
      frame_d = (cnt_d == '0) && (idx_d == '0);
    end
  end

  // Digit select from next-state plus the currently sampled blank and mask.
  always_comb begin
    sel_onehot_s = ONE_LSB << idx_d;
    digit_d      = ALL_OFF;
    case (state_d)
      S_ON: begin
        if (!i_blank && ((i_digit_mask & sel_onehot_s) != '0)) begin
          digit_d = SEL_ACTIVE_LOW ? ~sel_onehot_s : sel_onehot_s;
        end else begin
          digit_d = ALL_OFF;
        end
      end
      default: digit_d = ALL_OFF;
    endcase
  end

  assign o_digit       = digit_q;
  assign o_digit_idx   = idx_q;
  assign o_frame_start = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized bench for fnd_scan_controller; two instances (BLANK_CYCLES 2 and 0)
// checked against a time-position reference model.
module tb_fnd_scan_controller;
  localparam int N  = 4;
  localparam int RD = 8;

  logic       clk = 1'b0;
  logic       rst_n, en, blank;
  logic [3:0] mask;
  logic [3:0] dig_a, dig_b;
  logic [1:0] idx_a, idx_b;
  logic       frm_a, frm_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: active flag and cycles elapsed since the enabled run began
  bit         m_act = 1'b0;
  int         m_pos = 0;
  bit         m_blank = 1'b0;
  logic [3:0] m_mask = 4'hF;

  bit period_chk = 1'b0;
  int last_frame = -1;

  always #5 clk = ~clk;

  fnd_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEL_ACTIVE_LOW(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_blank(blank), .i_digit_mask(mask),
    .o_digit(dig_a), .o_digit_idx(idx_a), .o_frame_start(frm_a));

  fnd_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(0), .SEL_ACTIVE_LOW(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_blank(blank), .i_digit_mask(mask),
    .o_digit(dig_b), .o_digit_idx(idx_b), .o_frame_start(frm_b));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int exp_idx();
    return m_act ? (m_pos / RD) % N : 0;
  endfunction

  function automatic logic [3:0] exp_digit(input int bc);
    int k;
    logic [3:0] v;
    k = exp_idx();
    v = 4'hF;
    if (m_act && (m_pos % RD) >= bc && !m_blank && m_mask[k]) v[k] = 1'b0;
    return v;
  endfunction

  function automatic bit exp_frame();
    return m_act && (m_pos % (N * RD) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n || !en) begin
      m_act = 1'b0;
      m_pos = 0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
    m_blank = blank;
    m_mask  = mask;
    #1;
    chk("a_digit", dig_a, exp_digit(2));
    chk("a_idx",   idx_a, exp_idx());
    chk("a_frame", frm_a, exp_frame());
    chk("b_digit", dig_b, exp_digit(0));
    chk("b_idx",   idx_b, exp_idx());
    chk("b_frame", frm_b, exp_frame());
    if (m_act && m_mask == 4'hF && !m_blank)
      chk("b_one_low", $countones(~dig_b), 1);
    if (frm_a) begin
      if (period_chk && last_frame >= 0) chk("frame_gap", cyc - last_frame, N * RD);
      last_frame = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; blank = 1'b0; mask = 4'hF;
    run(3);
    // clean enabled run: frame gaps of 32, blank/on pattern per slot
    rst_n = 1'b1; en = 1'b1; period_chk = 1'b1; last_frame = -1;
    run(70);
    mask = 4'b1011;
    run(40);
    mask = 4'hF;
    // blank pulse inside slot 1 ON phase, then reset mid slot at idx 2
    while (!(m_act && m_pos % 32 == 11)) tick();
    blank = 1'b1; run(5); blank = 1'b0;
    while (!(m_act && m_pos % 32 == 20)) tick();
    rst_n = 1'b0; period_chk = 1'b0; run(1); rst_n = 1'b1;
    run(40);
    // enable drop at idx 3 for 3 cycles
    while (!(m_act && m_pos % 32 == 27)) tick();
    en = 1'b0; run(3); en = 1'b1;
    run(40);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      blank = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 40) == 0) mask = 4'($urandom);
      en    = ($urandom_range(0, 60) != 0);
      rst_n = ($urandom_range(0, 120) != 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
